wb_stage: RTL and testbench

Writeback stage at the consumer end of the MEM/WB pipeline register. Takes the registered MEM/WB control and data, waits on the data-memory read response for loads, and selects ALU result or extended load data. Drives the register-file write port one cycle after completion, and asserts a stall that freezes the MEM/WB register while a load response is outstanding.

---
 rtl/wb_pkg.sv | 14 +
 rtl/load_extend.sv | 36 +++
 rtl/wb_stage.sv | 155 +++++++++++++++
 tb/tb_wb_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: FSM state codes, load funct3 codes
// and the default load-timeout depth.
package wb_pkg;
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_MEM = 1'b1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a memory word and sign- or
// zero-extends it according to the load funct3 code.
module load_extend
    import wb_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        // addr_i[0] is deliberately ignored for halfwords (misaligned LH/LHU).
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        result_o = word_i;
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result_o = {24'd0, byte_sel};
            F3_LHU:  result_o = {16'd0, half_sel};
            default: result_o = word_i;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: waits on the data-memory response for loads, then drives the
// register-file write port. Optional load timeout via WB_LOAD_TIMEOUT_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_wb,
    input  logic        MemtoReg_wb,
    input  logic        RegWrite_wb,
    input  logic [31:0] ALU_OUT_wb,
    input  logic [2:0]  funct3_wb,
    input  logic [4:0]  RD_wb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        stall_wb,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        load_err
);
    logic [0:0]  state_q, state_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic [2:0]  cap_f3_q, cap_f3_d;
    logic [1:0]  cap_lane_q, cap_lane_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        stall_raw;
    logic        is_load, is_alu_wr, in_wait;
    logic [1:0]  ext_addr;
    logic [2:0]  ext_f3;
    logic [31:0] ext_data;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    assign is_load   = valid_wb & RegWrite_wb & MemtoReg_wb;
    assign is_alu_wr = valid_wb & RegWrite_wb & ~MemtoReg_wb;
    assign in_wait   = (state_q == ST_WAIT_MEM);

    // One extender serves both paths: captured fields while waiting, live ones in IDLE.
    assign ext_addr = in_wait ? cap_lane_q : ALU_OUT_wb[1:0];
    assign ext_f3   = in_wait ? cap_f3_q   : funct3_wb;

    load_extend u_ext (
        .word_i   (mem_rdata),
        .addr_i   (ext_addr),
        .funct3_i (ext_f3),
        .result_o (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cap_rd_d   = cap_rd_q;
        cap_f3_d   = cap_f3_q;
        cap_lane_d = cap_lane_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        stall_raw  = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (is_alu_wr) begin
                    rf_we_d    = (RD_wb != 5'd0);
                    rf_waddr_d = RD_wb;
                    rf_wdata_d = ALU_OUT_wb;
                end else if (is_load && mem_rvalid) begin
                    rf_we_d    = (RD_wb != 5'd0);
                    rf_waddr_d = RD_wb;
                    rf_wdata_d = ext_data;
                end else if (is_load) begin
                    stall_raw  = 1'b1;
                    cap_rd_d   = RD_wb;
                    cap_f3_d   = funct3_wb;
                    cap_lane_d = ALU_OUT_wb[1:0];
                    state_d    = ST_WAIT_MEM;
`ifdef WB_LOAD_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            default: begin
                if (mem_rvalid) begin
                    state_d    = ST_IDLE;
                    rf_we_d    = (cap_rd_q != 5'd0);
                    rf_waddr_d = cap_rd_q;
                    rf_wdata_d = ext_data;
                end else begin
                    stall_raw = 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
                    // Give up on the load: release the pipeline and flag it next cycle.
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        stall_raw = 1'b0;
                        state_d   = ST_IDLE;
                        err_d     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    assign stall_wb = reset & stall_raw;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cap_rd_q   <= '0;
            cap_f3_q   <= '0;
            cap_lane_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cap_rd_q   <= cap_rd_d;
            cap_f3_q   <= cap_f3_d;
            cap_lane_q <= cap_lane_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus random ALU/load/bubble
// traffic checked against a lane-arithmetic load model.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_wb, MemtoReg_wb, RegWrite_wb;
    logic [31:0] ALU_OUT_wb;
    logic [2:0]  funct3_wb;
    logic [4:0]  RD_wb;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        stall_wb, rf_we, load_err;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    wb_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .valid_wb(valid_wb), .MemtoReg_wb(MemtoReg_wb),
        .RegWrite_wb(RegWrite_wb), .ALU_OUT_wb(ALU_OUT_wb), .funct3_wb(funct3_wb),
        .RD_wb(RD_wb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .stall_wb(stall_wb), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference load result from byte/halfword arithmetic on the word.
    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3);
        logic [31:0] b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic bubble();
        valid_wb = 1'b0; MemtoReg_wb = 1'b0; RegWrite_wb = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_alu(input logic [4:0] rd, input logic [31:0] val);
        valid_wb = 1'b1; RegWrite_wb = 1'b1; MemtoReg_wb = 1'b0;
        ALU_OUT_wb = val; RD_wb = rd; funct3_wb = 3'($urandom_range(0, 7));
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        #1 chk("alu_stall", 32'(stall_wb), 32'd0);
        tick();
        bubble();
        chk("alu_we", 32'(rf_we), 32'(rd != 5'd0));
        chk("alu_waddr", 32'(rf_waddr), 32'(rd));
        chk("alu_wdata", rf_wdata, val);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] w, input int delay);
        valid_wb = 1'b1; RegWrite_wb = 1'b1; MemtoReg_wb = 1'b1;
        ALU_OUT_wb = addr; RD_wb = rd; funct3_wb = f3;
        for (int i = 0; i < delay; i++) begin
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            #1 chk("ld_stall_wait", 32'(stall_wb), 32'd1);
            tick();
            chk("ld_we_wait", 32'(rf_we), 32'd0);
            // Captured fields must be used while waiting, not the live inputs.
            RD_wb = 5'($urandom); ALU_OUT_wb = $urandom; funct3_wb = 3'($urandom);
        end
        mem_rvalid = 1'b1; mem_rdata = w;
        #1 chk("ld_stall_done", 32'(stall_wb), 32'd0);
        tick();
        bubble();
        chk("ld_we", 32'(rf_we), 32'(rd != 5'd0));
        chk("ld_waddr", 32'(rf_waddr), 32'(rd));
        chk("ld_wdata", rf_wdata, m_ext(w, addr[1:0], f3));
    endtask

    initial begin
        reset = 1'b0;
        valid_wb = 1'b1; RegWrite_wb = 1'b1; MemtoReg_wb = 1'b1;
        ALU_OUT_wb = 32'h3; funct3_wb = 3'd0; RD_wb = 5'd7;
        mem_rdata = 32'h0; mem_rvalid = 1'b0;
        #1 chk("rst_stall", 32'(stall_wb), 32'd0);
        tick(); tick();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        bubble();
        reset = 1'b1;
        tick();

        do_alu(5'd5, 32'h0000_1234);
        do_load(5'd9, 32'h0000_1003, 3'd0, 32'h80FF_FF7F, 0);
        chk("lb_value", rf_wdata, 32'hFFFF_FF80);
        do_load(5'd9, 32'h0000_1003, 3'd4, 32'h80FF_FF7F, 0);
        chk("lbu_value", rf_wdata, 32'h0000_0080);
        do_load(5'd11, 32'h0000_2002, 3'd1, 32'h8001_0000, 3);
        chk("lh_value", rf_wdata, 32'hFFFF_8001);
        do_load(5'd12, 32'h0000_2003, 3'd5, 32'h8001_0000, 1);
        chk("lhu_misalign", rf_wdata, 32'h0000_8001);
        do_alu(5'd0, 32'hDEAD_BEEF);
        do_load(5'd0, 32'h0000_0001, 3'd2, 32'hCAFE_F00D, 2);

        // Stray response with no load pending is ignored.
        bubble(); mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick(); bubble();
        chk("stray_rvalid_we", 32'(rf_we), 32'd0);

        // Reset during WAIT_MEM abandons the load.
        valid_wb = 1'b1; RegWrite_wb = 1'b1; MemtoReg_wb = 1'b1;
        ALU_OUT_wb = 32'h0; funct3_wb = 3'd2; RD_wb = 5'd3; mem_rvalid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1 chk("rstwait_stall", 32'(stall_wb), 32'd0);
        tick();
        chk("rstwait_we", 32'(rf_we), 32'd0);
        chk("rstwait_waddr", 32'(rf_waddr), 32'd0);
        reset = 1'b1; bubble();
        mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        #1 chk("late_rv_stall", 32'(stall_wb), 32'd0);
        tick(); bubble();
        chk("late_rv_we", 32'(rf_we), 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
        // TIMEOUT=4: entry cycle plus WAIT counts 0..2 stall, count 3 releases.
        valid_wb = 1'b1; RegWrite_wb = 1'b1; MemtoReg_wb = 1'b1;
        ALU_OUT_wb = 32'h0; funct3_wb = 3'd2; RD_wb = 5'd4; mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_stall", 32'(stall_wb), 32'd1);
            tick();
            chk("to_we", 32'(rf_we), 32'd0);
            chk("to_err_low", 32'(load_err), 32'd0);
        end
        #1 chk("to_release", 32'(stall_wb), 32'd0);
        tick(); bubble();
        chk("to_err_pulse", 32'(load_err), 32'd1);
        chk("to_no_write", 32'(rf_we), 32'd0);
        tick();
        chk("to_err_once", 32'(load_err), 32'd0);
        do_alu(5'd6, 32'h0000_5A5A);
`else
        chk("err_tied", 32'(load_err), 32'd0);
`endif

        // Random back-to-back traffic.
        for (int n = 0; n < 80; n++) begin
            int kind;
            logic [4:0] rd;
            kind = $urandom_range(0, 3);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            case (kind)
                0: do_alu(rd, $urandom);
                1: do_load(rd, $urandom, 3'($urandom), $urandom, 0);
                2: do_load(rd, $urandom, 3'($urandom), $urandom, $urandom_range(1, 3));
                default: begin
                    bubble();
                    valid_wb = $urandom_range(0, 1) != 0; RegWrite_wb = 1'b0;
                    MemtoReg_wb = $urandom_range(0, 1) != 0;
                    mem_rvalid = $urandom_range(0, 1) != 0;
                    #1 chk("bub_stall", 32'(stall_wb), 32'd0);
                    tick(); bubble();
                    chk("bub_we", 32'(rf_we), 32'd0);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
